// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch
//  Brief    : Fetch stage. Owns the PC and drives the 16-entry instruction
//             memory. Holds the fetched word in an instruction register and
//             hands it to decode with a valid/ready handshake.
//             Optional early jump is enabled by defining FETCH_EARLY_JUMP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter int ADDR_W   = 4,
    parameter int INSTR_W  = 16,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  addr,
    input  logic [INSTR_W-1:0] instruction,
    output logic               ir_enable,
    output logic [INSTR_W-1:0] ir_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               valid_out,
    input  logic               ready_in,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    input  logic               halt
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] c_pc_step  = ADDR_W'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    w_pc_nxt;
    logic [INSTR_W-1:0]   r_ir;
    logic [ADDR_W-1:0]    r_ir_pc;
    logic                 r_valid;
    logic                 w_can_load;
    logic                 w_capture;

    assign w_can_load = !r_valid || ready_in;

    // The memory read is combinational, so a capture happens in the same
    // cycle the address is presented.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_state_nxt = halt ? ST_HALT : ST_RUN;
        if (!reset && (r_state == ST_RUN) && w_can_load && !redirect_valid) begin
            w_capture = 1'b1;
        end
    end

`ifdef FETCH_EARLY_JUMP_EN
    // A jump opcode steers the PC right away; execute still redirects later.
    always_comb begin
        w_pc_nxt = r_pc + c_pc_step;
        if (instruction[INSTR_W-1:INSTR_W-4] == 4'b1011) begin
            w_pc_nxt = instruction[ADDR_W-1:0];
        end
    end
`else
    always_comb begin
        w_pc_nxt = r_pc + c_pc_step;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_pc    <= c_reset_pc;
            r_ir    <= '0;
            r_ir_pc <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_valid) begin
                // The held word is discarded even if decode is ready now.
                r_pc    <= redirect_target;
                r_valid <= 1'b0;
            end else if (w_capture) begin
                r_ir    <= instruction;
                r_ir_pc <= r_pc;
                r_valid <= 1'b1;
                r_pc    <= w_pc_nxt;
            end else if (ready_in) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign addr      = r_pc;
    assign ir_enable = w_capture;
    assign ir_out    = r_ir;
    assign pc_out    = r_ir_pc;
    assign valid_out = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_fetch
//  Brief    : Directed self-checking bench for instruction_fetch.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic [3:0]  addr;
    logic [15:0] instruction;
    logic        ir_enable;
    logic [15:0] ir_out;
    logic [3:0]  pc_out;
    logic        valid_out;
    logic        ready_in;
    logic        redirect_valid;
    logic [3:0]  redirect_target;
    logic        halt;

    logic [15:0] mem [16];
    int          n_cmp;
    int          n_fail;

    instruction_fetch #(
        .ADDR_W   (4),
        .INSTR_W  (16),
        .RESET_PC (0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .addr            (addr),
        .instruction     (instruction),
        .ir_enable       (ir_enable),
        .ir_out          (ir_out),
        .pc_out          (pc_out),
        .valid_out       (valid_out),
        .ready_in        (ready_in),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt            (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instruction = mem[addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic edge_tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h2000 | 16'(i * 16'h0011);
        reset           = 1'b1;
        ready_in        = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 4'd0;
        halt            = 1'b0;

        edge_tick();
        edge_tick();
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_pc_out", 32'(pc_out), 32'd0);
        check("rst_ir_out", 32'(ir_out), 32'd0);
        check("rst_ir_enable", 32'(ir_enable), 32'd0);
        reset = 1'b0;

        // Streaming with decode always ready, across the 15->0 wrap
        for (int k = 0; k < 20; k++) begin
            #1;
            check("run_ir_enable", 32'(ir_enable), 32'd1);
            check("run_addr", 32'(addr), 32'(k % 16));
            edge_tick();
            check("run_valid", 32'(valid_out), 32'd1);
            check("run_pc_out", 32'(pc_out), 32'(k % 16));
            check("run_ir_out", 32'(ir_out), 32'(mem[k % 16]));
        end

        // Stall three cycles holding word 3
        ready_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_ir_enable", 32'(ir_enable), 32'd0);
            edge_tick();
            check("stall_pc_out", 32'(pc_out), 32'd3);
            check("stall_ir_out", 32'(ir_out), 32'(mem[3]));
            check("stall_addr", 32'(addr), 32'd4);
            check("stall_valid", 32'(valid_out), 32'd1);
        end
        ready_in = 1'b1;
        edge_tick();
        check("unstall_pc_out", 32'(pc_out), 32'd4);

        // Redirect to 10 while stalled; ready high that cycle, word discarded
        ready_in = 1'b0;
        edge_tick();
        check("stall2_pc_out", 32'(pc_out), 32'd4);
        redirect_valid  = 1'b1;
        redirect_target = 4'd10;
        ready_in        = 1'b1;
        #1;
        check("redir_ir_enable", 32'(ir_enable), 32'd0);
        edge_tick();
        check("redir_valid", 32'(valid_out), 32'd0);
        check("redir_addr", 32'(addr), 32'd10);
        redirect_valid = 1'b0;
        #1;
        check("redir_next_ir_enable", 32'(ir_enable), 32'd1);
        edge_tick();
        check("redir_pc_out", 32'(pc_out), 32'd10);
        check("redir_ir_out", 32'(ir_out), 32'(mem[10]));

        // Redirect to 15 then wrap to 0
        redirect_valid  = 1'b1;
        redirect_target = 4'd15;
        edge_tick();
        check("r15_valid", 32'(valid_out), 32'd0);
        redirect_valid = 1'b0;
        edge_tick();
        check("r15_pc_out", 32'(pc_out), 32'd15);
        edge_tick();
        check("wrap_pc_out", 32'(pc_out), 32'd0);
        check("wrap_ir_out", 32'(ir_out), 32'(mem[0]));
        for (int k = 1; k <= 4; k++) begin
            edge_tick();
            check("adv_pc_out", 32'(pc_out), 32'(k));
        end

        // Halt with decode stalled on word 4
        halt     = 1'b1;
        ready_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("halt_ir_enable", 32'(ir_enable), 32'd0);
            edge_tick();
            check("halt_pc_out", 32'(pc_out), 32'd4);
            check("halt_valid", 32'(valid_out), 32'd1);
            check("halt_addr", 32'(addr), 32'd5);
        end
        ready_in = 1'b1;
        #1;
        check("halt_drain_ir_enable", 32'(ir_enable), 32'd0);
        edge_tick();
        check("halt_drain_valid", 32'(valid_out), 32'd0);
        check("halt_drain_addr", 32'(addr), 32'd5);
        edge_tick();
        check("halt_idle_valid", 32'(valid_out), 32'd0);
        check("halt_idle_addr", 32'(addr), 32'd5);
        halt = 1'b0;
        #1;
        check("halt_exit_ir_enable", 32'(ir_enable), 32'd0);
        edge_tick();
        check("halt_exit_valid", 32'(valid_out), 32'd0);
        #1;
        check("resume_ir_enable", 32'(ir_enable), 32'd1);
        edge_tick();
        check("resume_pc_out", 32'(pc_out), 32'd5);
        check("resume_valid", 32'(valid_out), 32'd1);

        // Redirect together with halt: redirect applied, then halted
        redirect_valid  = 1'b1;
        redirect_target = 4'd9;
        halt            = 1'b1;
        edge_tick();
        check("rh_valid", 32'(valid_out), 32'd0);
        check("rh_addr", 32'(addr), 32'd9);
        redirect_valid = 1'b0;
        #1;
        check("rh_ir_enable", 32'(ir_enable), 32'd0);
        edge_tick();
        check("rh_hold_valid", 32'(valid_out), 32'd0);
        check("rh_hold_addr", 32'(addr), 32'd9);
        halt = 1'b0;
        edge_tick();
        edge_tick();
        check("rh_resume_pc_out", 32'(pc_out), 32'd9);

        // Reset in the middle of a stall
        ready_in = 1'b0;
        edge_tick();
        check("pre_rst_pc_out", 32'(pc_out), 32'd9);
        reset = 1'b1;
        edge_tick();
        check("mid_rst_valid", 32'(valid_out), 32'd0);
        check("mid_rst_addr", 32'(addr), 32'd0);
        check("mid_rst_pc_out", 32'(pc_out), 32'd0);
        reset    = 1'b0;
        ready_in = 1'b1;

        // Jump opcode at address 7
        mem[7]          = 16'hB000;
        redirect_valid  = 1'b1;
        redirect_target = 4'd7;
        edge_tick();
        redirect_valid = 1'b0;
        edge_tick();
        check("jmp_pc_out", 32'(pc_out), 32'd7);
        check("jmp_ir_out", 32'(ir_out), 32'h0000B000);
`ifdef FETCH_EARLY_JUMP_EN
        check("jmp_addr", 32'(addr), 32'd0);
        edge_tick();
        check("jmp_next_pc_out", 32'(pc_out), 32'd0);
`else
        check("jmp_addr", 32'(addr), 32'd8);
        edge_tick();
        check("jmp_next_pc_out", 32'(pc_out), 32'd8);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
